// File: rtl/cam_frame_sram_writer.sv
// cam_frame_sram_writer: buffers camera pixel writes in a FIFO and commits them to async SRAM
// with timed active-low write pulses, ping-ponging whole frames across SRAM banks.
module cam_frame_sram_writer #(
    parameter int DATA_W      = 16,
    parameter int PIX_ADDR_W  = 17,
    parameter int SRAM_ADDR_W = 19,
    parameter int NUM_BANKS   = 2,
    parameter int FIFO_DEPTH  = 8,
    parameter int WE_CYCLES   = 2,
    localparam int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   wclk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [PIX_ADDR_W-1:0]  cam_addr,
    input  logic [DATA_W-1:0]      cam_data,
    input  logic                   cam_we,
    input  logic                   cam_frame_end,
    output logic                   sram_ce_n,
    output logic                   sram_we_n,
    output logic                   sram_oe_n,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0]      sram_wdata,
    output logic [BANK_W-1:0]      wr_bank,
    output logic [BANK_W-1:0]      rd_bank,
    output logic [LVL_W-1:0]       fifo_level,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);
    localparam int AW    = LVL_W - 1;
    localparam int CNT_W = $clog2(WE_CYCLES + 1);
    localparam logic [AW:0]       PTR_ONE = LVL_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(WE_CYCLES);
    localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(NUM_BANKS - 1);

    typedef enum logic [1:0] {IDLE, SETUP, WRITE, HOLD} state_t;

    state_t                        state_q;
    logic [PIX_ADDR_W+DATA_W-1:0]  mem_q [FIFO_DEPTH];
    logic [AW:0]                   wp_q, rp_q;
    logic [CNT_W-1:0]              cnt_q;
    logic                          ce_n_q, we_n_q, pending_q, done_q, ovf_q;
    logic [SRAM_ADDR_W-1:0]        addr_q;
    logic [DATA_W-1:0]             wdata_q;
    logic [BANK_W-1:0]             wr_bank_q, rd_bank_q;

    logic [AW:0]                   level;
    logic                          empty, full, slot, pop, req, push, done_d, pending_d;
    logic [BANK_W-1:0]             bank_d;
    logic [PIX_ADDR_W-1:0]         head_addr;
    logic [DATA_W-1:0]             head_data;
    logic [SRAM_ADDR_W-1:0]        head_sram;

    // IDLE and HOLD are the only states that may pop or retire a frame
    always_comb begin
        level     = wp_q - rp_q;
        empty     = level == '0;
        full      = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
        slot      = state_q == IDLE || state_q == HOLD;
        pop       = !empty && slot;
        req       = cam_we && enable;
        push      = req && (!full || pop);
        done_d    = pending_q && empty && slot;
        pending_d = !done_d && (pending_q || cam_frame_end);
        bank_d    = (wr_bank_q == BANK_LAST) ? '0 : wr_bank_q + BANK_W'(1);
    end

    assign {head_addr, head_data} = mem_q[rp_q[AW-1:0]];
    assign head_sram = SRAM_ADDR_W'({wr_bank_q, head_addr});

    always_ff @(posedge wclk) begin
        if (push) mem_q[wp_q[AW-1:0]] <= {cam_addr, cam_data};
    end

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wp_q      <= '0;
            rp_q      <= '0;
            cnt_q     <= '0;
            ce_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            wr_bank_q <= '0;
            rd_bank_q <= BANK_LAST;
        end else begin
            if (push) wp_q <= wp_q + PTR_ONE;
            if (pop) rp_q <= rp_q + PTR_ONE;
            if (req && !push) ovf_q <= 1'b1;
            done_q    <= done_d;
            pending_q <= pending_d;
            if (done_d) begin
                rd_bank_q <= wr_bank_q;
                wr_bank_q <= bank_d;
            end
            case (state_q)
                IDLE, HOLD: begin
                    if (pop) begin
                        addr_q  <= head_sram;
                        wdata_q <= head_data;
                        ce_n_q  <= 1'b0;
                        state_q <= SETUP;
                    end else begin
                        ce_n_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                SETUP: begin
                    we_n_q  <= 1'b0;
                    cnt_q   <= CNT_ONE;
                    state_q <= WRITE;
                end
                WRITE: begin
                    if (cnt_q == CNT_MAX) begin
                        we_n_q  <= 1'b1;
                        state_q <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sram_ce_n  = ce_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_oe_n  = 1'b1;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign wr_bank    = wr_bank_q;
    assign rd_bank    = rd_bank_q;
    assign fifo_level = level;
    assign busy       = !empty || state_q != IDLE;
    assign done       = done_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_cam_frame_sram_writer.sv
// tb_cam_frame_sram_writer: directed and random camera traffic checked every cycle against a
// transaction-level model (pixel queue, write-slot timing, frame/bank bookkeeping).
module tb_cam_frame_sram_writer;
    localparam int DW = 16, PW = 17, SW = 19, NB = 2, FD = 8, WE = 2, BW = 1, LW = 4;

    logic          wclk = 1'b0, rst_n = 1'b0, enable = 1'b0, cam_we = 1'b0, cam_frame_end = 1'b0;
    logic [PW-1:0] cam_addr = '0;
    logic [DW-1:0] cam_data = '0;
    logic          sram_ce_n, sram_we_n, sram_oe_n, busy, done, overflow;
    logic [SW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [BW-1:0] wr_bank, rd_bank;
    logic [LW-1:0] fifo_level;

    always #5 wclk = ~wclk;

    cam_frame_sram_writer #(
        .DATA_W(DW), .PIX_ADDR_W(PW), .SRAM_ADDR_W(SW),
        .NUM_BANKS(NB), .FIFO_DEPTH(FD), .WE_CYCLES(WE)
    ) dut (
        .wclk(wclk), .rst_n(rst_n), .enable(enable), .cam_addr(cam_addr), .cam_data(cam_data),
        .cam_we(cam_we), .cam_frame_end(cam_frame_end), .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n),
        .sram_oe_n(sram_oe_n), .sram_addr(sram_addr), .sram_wdata(sram_wdata), .wr_bank(wr_bank),
        .rd_bank(rd_bank), .fifo_level(fifo_level), .busy(busy), .done(done), .overflow(overflow)
    );

    int n_chk = 0, n_fail = 0, done_seen = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: e counts clock edges; a popped word owns the SRAM until edge free_e
    logic [PW+DW-1:0] mq[$];
    int               e, free_e, last_p, wr_b, rd_b;
    bit               pend, ovf, done_m;
    logic [SW-1:0]    x_addr;
    logic [DW-1:0]    x_data;

    task automatic model_reset();
        mq.delete();
        e = 0; free_e = 0; last_p = -100;
        pend = 0; ovf = 0; done_m = 0;
        wr_b = 0; rd_b = NB - 1;
        x_addr = '0; x_data = '0;
    endtask

    task automatic model_edge();
        int sz;
        bit can_pop, try_w, acc;
        logic [PW+DW-1:0] ent;
        e++;
        sz      = mq.size();
        can_pop = sz > 0 && e >= free_e;
        try_w   = cam_we && enable;
        acc     = try_w && (sz < FD || can_pop);
        if (try_w && !acc) ovf = 1;
        done_m  = pend && sz == 0 && e >= free_e;
        if (can_pop) begin
            ent    = mq.pop_front();
            x_addr = SW'(wr_b * (1 << PW) + int'(ent[PW+DW-1:DW]));
            x_data = ent[DW-1:0];
            last_p = e;
            free_e = e + WE + 2;
        end
        if (acc) mq.push_back({cam_addr, cam_data});
        if (done_m) begin
            rd_b = wr_b;
            wr_b = (wr_b + 1) % NB;
        end
        pend = !done_m && (pend || cam_frame_end);
    endtask

    task automatic check_all();
        if (done === 1'b1) done_seen++;
        chk("fifo_level", 32'(fifo_level), mq.size());
        chk("busy", 32'(busy), 32'(mq.size() > 0 || e < free_e));
        chk("ce_n", 32'(sram_ce_n), 32'(e >= free_e));
        chk("we_n", 32'(sram_we_n), 32'(!(e >= last_p + 1 && e <= last_p + WE)));
        chk("oe_n", 32'(sram_oe_n), 1);
        chk("sram_addr", 32'(sram_addr), 32'(x_addr));
        chk("sram_wdata", 32'(sram_wdata), 32'(x_data));
        chk("done", 32'(done), 32'(done_m));
        chk("overflow", 32'(overflow), 32'(ovf));
        chk("wr_bank", 32'(wr_bank), wr_b);
        chk("rd_bank", 32'(rd_bank), rd_b);
    endtask

    task automatic cyc(input bit we, input bit en, input bit fe, input logic [PW-1:0] a, input logic [DW-1:0] d);
        cam_we = we; enable = en; cam_frame_end = fe; cam_addr = a; cam_data = d;
        @(posedge wclk);
        model_edge();
        @(negedge wclk);
        check_all();
        cam_we = 1'b0; cam_frame_end = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b1, 1'b0, '0, '0);
    endtask

    initial begin
        int d0;
        model_reset();
        repeat (3) @(posedge wclk);
        @(negedge wclk);
        rst_n = 1'b1;
        check_all();

        cyc(1, 1, 0, 17'h00005, 16'hABCD);
        idle(1);
        chk("single_addr", 32'(sram_addr), 32'h5);
        chk("single_data", 32'(sram_wdata), 32'hABCD);
        idle(6);

        for (int i = 0; i < 8; i++) cyc(1, 1, 0, PW'(i), DW'(32'h1000 + i));
        idle(40);
        chk("burst_no_ovf", 32'(overflow), 0);

        for (int i = 0; i < 12; i++) cyc(1, 1, 0, PW'(32'h100 + i), DW'(32'h3000 + i));
        chk("ovf_set", 32'(overflow), 1);
        idle(60);

        cyc(1, 1, 0, 17'h1FFFF, 16'h1111);
        cyc(0, 0, 1, '0, '0);
        chk("pp_addr_a", 32'(sram_addr), 32'h1FFFF);
        idle(8);
        cyc(1, 1, 0, 17'h00000, 16'h2222);
        cyc(0, 0, 1, '0, '0);
        chk("pp_addr_b", 32'(sram_addr), 32'h20000);
        idle(8);
        chk("pp_wr_bank", 32'(wr_bank), 0);
        chk("pp_rd_bank", 32'(rd_bank), 1);

        d0 = done_seen;
        cyc(1, 1, 0, 17'h00010, 16'h5001);
        cyc(1, 1, 0, 17'h00011, 16'h5002);
        cyc(1, 1, 1, 17'h00012, 16'h5003);
        cyc(0, 1, 1, '0, '0);
        idle(20);
        chk("fe_done_count", done_seen - d0, 1);

        for (int b = 0; b < 20; b++) begin
            int p;
            p = int'($urandom_range(1, 9));
            for (int i = 0; i < 100; i++)
                cyc(int'($urandom_range(0, 9)) < p, $urandom_range(0, 7) != 0,
                    $urandom_range(0, 49) == 0, PW'($urandom), DW'($urandom));
        end
        idle(80);

        if (wr_b == 0) begin
            cyc(0, 1, 1, '0, '0);
            idle(6);
        end
        cyc(1, 1, 0, 17'h00020, 16'h7001);
        cyc(1, 1, 0, 17'h00021, 16'h7002);
        cyc(1, 1, 0, 17'h00022, 16'h7003);
        chk("pre_rst_we_n", 32'(sram_we_n), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_we_n", 32'(sram_we_n), 1);
        chk("rst_ce_n", 32'(sram_ce_n), 1);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_wr_bank", 32'(wr_bank), 0);
        chk("rst_rd_bank", 32'(rd_bank), NB - 1);
        repeat (2) @(posedge wclk);
        @(negedge wclk);
        rst_n = 1'b1;
        model_reset();
        check_all();

        for (int i = 0; i < 6; i++) cyc(1, 0, 0, PW'($urandom), DW'($urandom));
        idle(4);
        chk("dis_ovf", 32'(overflow), 0);
        chk("dis_level", 32'(fifo_level), 0);
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
